// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access size codes,
// FSM state encoding and wait-state counter width.
package dmem_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: load lane select with sign/zero extension, and
// store byte-enable generation with write-data replication across lanes.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        zero_ext,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    byte_en   = 4'hf;
    wdata_rep = wdata;
    rdata     = rword;
    lane_b    = rword[{offset, 3'b000} +: 8];
    lane_h    = offset[1] ? rword[31:16] : rword[15:0];
    case (size)
      SIZE_B: begin
        byte_en   = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
        rdata     = zero_ext ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      end
      SIZE_H: begin
        byte_en   = offset[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata     = zero_ext ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      end
      default: begin
        // Word and the reserved size code both take the full word.
        byte_en   = 4'hf;
        wdata_rep = wdata;
        rdata     = rword;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one sized load/store at a time over valid/ready,
// with WAIT_CYCLES wait states. Define DMEM_ERR_EN to report misaligned and
// out-of-range accesses; otherwise addresses are masked and wrap.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk1,
  input  logic        reset1,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              q_we;
  logic [31:0]       q_addr;
  logic [31:0]       q_wdata;
  logic [1:0]        q_size;
  logic              q_unsigned;

  logic              c_we;
  logic [31:0]       c_addr;
  logic [31:0]       c_wdata;
  logic [1:0]        c_size;
  logic              c_unsigned;

  logic              accept;
  logic              go_resp;
  logic              fault;
  logic [31:0]       eff_addr;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       rword;
  logic [3:0]        byte_en;
  logic [31:0]       wdata_rep;
  logic [31:0]       ext_rdata;
  logic [31:0]       resp_rdata;

  logic [31:0]       mem [DEPTH_WORDS];

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && (state == IDLE);

  // With zero wait states the commit edge is the acceptance edge, so the
  // live request fields feed the access instead of the captured ones.
  always_comb begin
    if (state == IDLE) begin
      c_we       = req_we;
      c_addr     = req_addr;
      c_wdata    = req_wdata;
      c_size     = req_size;
      c_unsigned = req_unsigned;
    end else begin
      c_we       = q_we;
      c_addr     = q_addr;
      c_wdata    = q_wdata;
      c_size     = q_size;
      c_unsigned = q_unsigned;
    end
  end

  assign go_resp = !reset1 &&
                   ((accept && (WAIT_CYCLES == 0)) ||
                    ((state == WAIT) && (cnt == '0)));

`ifdef DMEM_ERR_EN
  logic misaligned;
  logic out_of_range;

  assign misaligned   = ((c_size == SIZE_H) && c_addr[0]) ||
                        (c_size[1] && (c_addr[1:0] != 2'b00));
  assign out_of_range = (c_addr[31:ADDR_W+2] != '0);
  assign fault        = misaligned || out_of_range;
  assign eff_addr     = c_addr;
`else
  // Upper bits are dropped so the RAM wraps; low bits are forced aligned.
  logic unused_addr_bits;

  assign unused_addr_bits = ^c_addr[31:ADDR_W+2];
  assign fault            = 1'b0;
  always_comb begin
    eff_addr = c_addr;
    if (c_size[1])
      eff_addr[1:0] = 2'b00;
    else if (c_size == SIZE_H)
      eff_addr[0] = 1'b0;
  end
`endif

  assign word_idx = eff_addr[ADDR_W+1:2];
  assign rword    = mem[word_idx];

  dmem_lane_align u_lane_align (
    .size      (c_size),
    .zero_ext  (c_unsigned),
    .offset    (eff_addr[1:0]),
    .wdata     (c_wdata),
    .rword     (rword),
    .byte_en   (byte_en),
    .wdata_rep (wdata_rep),
    .rdata     (ext_rdata)
  );

  assign resp_rdata = (c_we || fault) ? 32'h0 : ext_rdata;

  // NOTE: the RAM has no reset; its contents are undefined until written.
  always_ff @(posedge clk1) begin
    if (go_resp && c_we && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i])
          mem[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk1 or posedge reset1) begin
    if (reset1) begin
      state      <= IDLE;
      cnt        <= '0;
      q_we       <= 1'b0;
      q_addr     <= '0;
      q_wdata    <= '0;
      q_size     <= SIZE_B;
      q_unsigned <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            q_we       <= req_we;
            q_addr     <= req_addr;
            q_wdata    <= req_wdata;
            q_size     <= req_size;
            q_unsigned <= req_unsigned;
            if (WAIT_CYCLES == 0) begin
              state     <= RESP;
              rsp_rdata <= resp_rdata;
              rsp_err   <= fault;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state     <= RESP;
            rsp_rdata <= resp_rdata;
            rsp_err   <= fault;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed requests push expected
// responses; a negedge monitor pops and compares on each response handshake.
module tb_data_mem_responder;

  localparam int DEPTH_WORDS = 256;
  localparam int WAIT_CYCLES = 1;

  logic        clk1 = 1'b0;
  logic        reset1 = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  data_mem_responder #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk1         (clk1),
    .reset1       (reset1),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  always #5 clk1 = ~clk1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, wanted 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: one pop per response handshake.
  always @(negedge clk1) begin
    if (!reset1 && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_response", 32'h1, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, ".rdata"}, rsp_rdata, e.rdata);
        check({e.name, ".err"}, {31'h0, rsp_err}, {31'h0, e.err});
      end
    end
  end

  // Present a request and return just after its acceptance edge.
  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [1:0] size, input logic uns,
                      input logic [31:0] exp_rdata, input logic exp_err,
                      input string name, input bit push);
    int n;
    if (push) sb.push_back('{exp_rdata, exp_err, name});
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = addr;
    req_wdata    = wdata;
    req_size     = size;
    req_unsigned = uns;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk1); #1;
      n++;
    end
    if (n >= 50) check({name, ".accept_timeout"}, 32'h1, 32'h0);
    @(posedge clk1); #1;
    // Scramble fields: the DUT must have captured them at acceptance.
    req_valid    = 1'b0;
    req_we       = ~we;
    req_addr     = 32'hFFFF_FFFF;
    req_wdata    = 32'hA5A5_A5A5;
    req_size     = 2'd0;
    req_unsigned = ~uns;
  endtask

  task automatic wait_rsp(input string name);
    int k;
    k = 0;
    while (!rsp_valid && k < 50) begin
      @(posedge clk1); #1;
      k++;
    end
    check({name, ".latency"}, k, WAIT_CYCLES);
  endtask

  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [1:0] size, input logic uns,
                      input logic [31:0] exp_rdata, input logic exp_err, input string name);
    send(we, addr, wdata, size, uns, exp_rdata, exp_err, name, 1'b1);
    wait_rsp(name);
    @(posedge clk1); #1;
  endtask

  logic [31:0] w10_now;

  initial begin
    // Reset state
    #2;
    check("rst.req_ready", {31'h0, req_ready}, 32'h1);
    check("rst.rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst.rsp_rdata", rsp_rdata, 32'h0);
    check("rst.rsp_err", {31'h0, rsp_err}, 32'h0);
    repeat (3) @(posedge clk1);
    #1 reset1 = 1'b0;

    // Word store / load and extension
    xfer(1, 32'h10, 32'hDEADBEEF, 2'd2, 0, 32'h0, 0, "sw_10");
    xfer(0, 32'h10, 32'h0, 2'd2, 0, 32'hDEADBEEF, 0, "lw_10");
    xfer(0, 32'h13, 32'h0, 2'd0, 0, 32'hFFFFFFDE, 0, "lb_13");
    xfer(0, 32'h13, 32'h0, 2'd0, 1, 32'h000000DE, 0, "lbu_13");
    xfer(0, 32'h10, 32'h0, 2'd1, 0, 32'hFFFFBEEF, 0, "lh_10");
    xfer(0, 32'h12, 32'h0, 2'd1, 1, 32'h0000DEAD, 0, "lhu_12");

    // Lane merge
    xfer(1, 32'h11, 32'hAAAAAA55, 2'd0, 0, 32'h0, 0, "sb_11");
    xfer(0, 32'h10, 32'h0, 2'd2, 0, 32'hDEAD55EF, 0, "lw_10_merged");
    xfer(1, 32'h14, 32'h0, 2'd2, 0, 32'h0, 0, "sw_14");
    xfer(1, 32'h16, 32'hFFFF8001, 2'd1, 0, 32'h0, 0, "sh_16");
    xfer(0, 32'h14, 32'h0, 2'd2, 0, 32'h80010000, 0, "lw_14");
    xfer(0, 32'h16, 32'h0, 2'd1, 0, 32'hFFFF8001, 0, "lh_16");
    xfer(0, 32'h14, 32'h0, 2'd3, 0, 32'h80010000, 0, "lw_rsvd_size");

    // Backpressure
    rsp_ready = 1'b0;
    send(0, 32'h10, 32'h0, 2'd2, 0, 32'hDEAD55EF, 0, "bp_lw", 1'b1);
    wait_rsp("bp_lw");
    for (int c = 0; c < 5; c++) begin
      check("bp.rsp_valid", {31'h0, rsp_valid}, 32'h1);
      check("bp.rsp_rdata", rsp_rdata, 32'hDEAD55EF);
      check("bp.req_ready", {31'h0, req_ready}, 32'h0);
      @(posedge clk1); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk1); #1;
    check("bp.done_valid", {31'h0, rsp_valid}, 32'h0);
    check("bp.done_ready", {31'h0, req_ready}, 32'h1);

    // Faults / address masking
    xfer(1, 32'h0, 32'hCAFEF00D, 2'd2, 0, 32'h0, 0, "sw_0");
`ifdef DMEM_ERR_EN
    xfer(1, 32'h12, 32'h12345678, 2'd2, 0, 32'h0, 1, "sw_misaligned");
    xfer(0, 32'h10, 32'h0, 2'd2, 0, 32'hDEAD55EF, 0, "lw_after_fault");
    xfer(0, DEPTH_WORDS * 4, 32'h0, 2'd2, 0, 32'h0, 1, "lw_oor");
    xfer(0, 32'h11, 32'h0, 2'd1, 0, 32'h0, 1, "lh_misaligned");
    w10_now = 32'hDEAD55EF;
`else
    xfer(1, 32'h12, 32'h12345678, 2'd2, 0, 32'h0, 0, "sw_masked");
    xfer(0, 32'h10, 32'h0, 2'd2, 0, 32'h12345678, 0, "lw_after_mask");
    xfer(0, DEPTH_WORDS * 4, 32'h0, 2'd2, 0, 32'hCAFEF00D, 0, "lw_wrap");
    xfer(0, 32'h11, 32'h0, 2'd1, 0, 32'h00005678, 0, "lh_masked");
    w10_now = 32'h12345678;
`endif

    // Reset during WAIT abandons the store
    send(1, 32'h10, 32'h0, 2'd2, 0, 32'h0, 0, "sw_reset", 1'b0);
    reset1 = 1'b1;
    #1;
    check("mid_rst.req_ready", {31'h0, req_ready}, 32'h1);
    check("mid_rst.rsp_valid", {31'h0, rsp_valid}, 32'h0);
    @(posedge clk1); #1;
    reset1 = 1'b0;
    check("post_rst.req_ready", {31'h0, req_ready}, 32'h1);
    xfer(0, 32'h10, 32'h0, 2'd2, 0, w10_now, 0, "lw_after_reset");

    repeat (2) @(posedge clk1);
    check("scoreboard_empty", sb.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
